rvh_l1d_entry_alloc_sched: RTL and testbench
============================================

// Module: rvh_l1d_entry_alloc_sched
// PURPOSE
//  Multi-port allocation scheduler for a pool of L1D tracking entries (MSHR / line-fill slots).
//  Each cycle it grants up to REQ_NUM requesters a free entry index:
//   - lowest free indices first
//   - requester priority rotates round-robin under contention
//  Keeps a registered busy bitmap with population count and full/empty status for upstream stall logic.
// PARAMETERS
//  ENTRY_NUM  8                      number of entries in the pool; >= REQ_NUM
//  REQ_NUM    2                      number of allocation request ports; >= 1
//  IDX_W      $clog2(ENTRY_NUM)      entry index width (1 when ENTRY_NUM==1)
//  CNT_W      $clog2(ENTRY_NUM)+1    occupancy count width
// PORTS
//  clk         in   1              clock
//  rst         in   1              asynchronous reset, active-high
//  req_vld_i   in   REQ_NUM        per-port allocation request
//  req_rdy_o   out  REQ_NUM        per-port grant; allocation occurs on vld & rdy
//  req_idx_o   out  REQ_NUM*IDX_W  granted entry index, port p at [p*IDX_W +: IDX_W]
//  rel_vld_i   in   ENTRY_NUM      release bitmask, one bit per entry
//  flush_i     in   1              release all entries, block all grants this cycle
//  busy_vec_o  out  ENTRY_NUM      registered busy bitmap
//  busy_cnt_o  out  CNT_W          popcount(busy_vec_o), registered
//  free_cnt_o  out  CNT_W          ENTRY_NUM - busy_cnt_o
//  full_o      out  1              busy_cnt_o == ENTRY_NUM
//  empty_o     out  1              busy_cnt_o == 0
// BEHAVIOUR
//  Reset (async): busy_vec=0, busy_cnt=0, rr_ptr=0.
//   Outputs at reset: free_cnt=ENTRY_NUM, full=0, empty=1, req_rdy=0, req_idx=0.
//  Grant path (combinational from registered busy_vec, req_vld_i, rr_ptr, flush_i):
//   - Scan ports in order rr_ptr, rr_ptr+1, ... mod REQ_NUM.
//   - The k-th requesting port (k=0..) is granted iff k < free_cnt.
//   - The k-th granted port receives the k-th lowest free index.
//   - req_rdy_o[p] is 0 when req_vld_i[p]=0 or flush_i=1.
//   - req_idx_o[p] is 0 for any port not granted.
//   - No two ports are ever granted the same index.
//  Latency: granted entries read busy on the next cycle.
//   busy_cnt_o and full/empty update in the same cycle as busy_vec_o.
//  Release:
//   - rel_vld_i[i]=1 frees entry i at the next edge.
//   - A released entry is not re-grantable in the cycle it is released; free set = registered state only.
//   - Releasing an entry that is not busy is a no-op.
//   - rel_vld_i may have any number of bits set.
//  Simultaneous events: next busy_vec = (busy_vec & ~rel_vld_i) | grant_mask.
//   grant_mask covers only free entries, so it never collides with a release.
//   next busy_cnt = popcount(next busy_vec), computed with one_counter #(ENTRY_NUM).
//  Flush: flush_i=1 forces next busy_vec=0 and busy_cnt=0, and no grants that cycle.
//   rr_ptr is unchanged. Flush overrides releases.
//  Round-robin pointer:
//   - If >=1 port is granted and >=1 requesting port is denied, rr_ptr <= (last granted port in scan order + 1) mod REQ_NUM.
//   - Otherwise rr_ptr holds.
//   - REQ_NUM==1: rr_ptr is constant 0.
//  Full: no grants; releases still take effect.
//  Empty: all requesting ports are granted, up to REQ_NUM.
//  Reset mid-operation: all state returns to reset values immediately; in-flight grants are discarded.
//  Sim-only assertions:
//   - busy_cnt_o == popcount(busy_vec_o) every cycle.
//   - No duplicate granted indices.
// TESTING
//  T1 reset, ENTRY_NUM=8, REQ_NUM=2, vld=2'b11 for 4 cycles -> idx pairs (0,1),(2,3),(4,5),(6,7); then full_o=1, rdy=0.
//  T2 full pool, rel_vld_i=8'h05 with vld=2'b11 -> no grant that cycle; next cycle grants idx 0 and 2, busy_cnt 6 -> 8.
//  T3 free_cnt=1, vld=2'b11 repeated -> grants alternate port0, port1, port0 (rr_ptr 0->1->0), one release per cycle.
//  T4 busy_vec=8'hFF, flush_i=1 with vld=2'b11 -> rdy=0; next cycle busy_vec=0, empty_o=1, free_cnt=8.
//  T5 release of non-busy entry 3 while busy_vec=8'h01 -> busy_vec stays 8'h01, busy_cnt stays 1.
//  T6 async rst asserted mid-allocation -> outputs at reset values before the next edge; random stress vs. a reference model checks the assertions.

Source files
------------

// File: rtl/rvh_l1d_entry_alloc_sched.sv
// Allocation scheduler for L1D tracking entries: grants free entry indices to up to
// REQ_NUM requesters per cycle, lowest free index first, with round-robin port priority.

module one_counter #(
   parameter int N     = 8,
   parameter int CNT_W = $clog2(N) + 1
) (
   input  logic [N-1:0]     vec,
   output logic [CNT_W-1:0] cnt
);
   always_comb begin
      cnt = '0;
      for (int i = 0; i < N; i++) begin
         cnt = cnt + CNT_W'(vec[i]);
      end
   end
endmodule

module rvh_l1d_entry_alloc_sched #(
   parameter int ENTRY_NUM = 8,
   parameter int REQ_NUM   = 2,
   parameter int IDX_W     = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1,
   parameter int CNT_W     = $clog2(ENTRY_NUM) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [REQ_NUM-1:0]       req_vld_i,
   output logic [REQ_NUM-1:0]       req_rdy_o,
   output logic [REQ_NUM*IDX_W-1:0] req_idx_o,
   input  logic [ENTRY_NUM-1:0]     rel_vld_i,
   input  logic                     flush_i,
   output logic [ENTRY_NUM-1:0]     busy_vec_o,
   output logic [CNT_W-1:0]         busy_cnt_o,
   output logic [CNT_W-1:0]         free_cnt_o,
   output logic                     full_o,
   output logic                     empty_o
);
   localparam int RR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

   logic [ENTRY_NUM-1:0] busy_q;
   logic [ENTRY_NUM-1:0] busy_nxt;
   logic [CNT_W-1:0]     busy_cnt_q;
   logic [CNT_W-1:0]     busy_cnt_nxt;
   logic [RR_W-1:0]      rr_q;
   logic [RR_W-1:0]      rr_nxt;
   logic [ENTRY_NUM-1:0] avail;
   logic [ENTRY_NUM-1:0] grant_mask;
   logic                 any_gnt;
   logic                 any_deny;
   logic                 found;
   int                   port;
   int                   sel;
   int                   last_gnt;

   // Each requesting port in rotated order takes the lowest entry still available,
   // so the k-th requester gets the k-th lowest free index while entries remain.
   always_comb begin
      avail      = ~busy_q;
      grant_mask = '0;
      req_rdy_o  = '0;
      req_idx_o  = '0;
      any_gnt    = 1'b0;
      any_deny   = 1'b0;
      found      = 1'b0;
      port       = 0;
      sel        = 0;
      last_gnt   = 0;
      for (int k = 0; k < REQ_NUM; k++) begin
         port = int'(rr_q) + k;
         if (port >= REQ_NUM) port = port - REQ_NUM;
         if (req_vld_i[port] && !flush_i && !rst) begin
            found = 1'b0;
            sel   = 0;
            for (int i = 0; i < ENTRY_NUM; i++) begin
               if (!found && avail[i]) begin
                  found = 1'b1;
                  sel   = i;
               end
            end
            if (found) begin
               req_rdy_o[port]                   = 1'b1;
               req_idx_o[port*IDX_W +: IDX_W]    = IDX_W'(sel);
               avail[sel]                        = 1'b0;
               grant_mask[sel]                   = 1'b1;
               any_gnt                           = 1'b1;
               last_gnt                          = port;
            end else begin
               any_deny = 1'b1;
            end
         end
      end
   end

   always_comb begin
      rr_nxt = rr_q;
      if (any_gnt && any_deny) begin
         rr_nxt = (last_gnt + 1 >= REQ_NUM) ? '0 : RR_W'(last_gnt + 1);
      end
   end

   // Grants only cover free entries, so they never overlap a release.
   assign busy_nxt = flush_i ? '0 : ((busy_q & ~rel_vld_i) | grant_mask);

   one_counter #(.N(ENTRY_NUM), .CNT_W(CNT_W)) u_busy_cnt (
      .vec (busy_nxt),
      .cnt (busy_cnt_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q     <= '0;
         busy_cnt_q <= '0;
         rr_q       <= '0;
      end else begin
         busy_q     <= busy_nxt;
         busy_cnt_q <= busy_cnt_nxt;
         rr_q       <= rr_nxt;
      end
   end

   assign busy_vec_o = busy_q;
   assign busy_cnt_o = busy_cnt_q;
   assign free_cnt_o = CNT_W'(ENTRY_NUM) - busy_cnt_q;
   assign full_o     = (busy_cnt_q == CNT_W'(ENTRY_NUM));
   assign empty_o    = (busy_cnt_q == '0);

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!rst) begin
         assert (busy_cnt_q == CNT_W'($countones(busy_q)));
         for (int p = 0; p < REQ_NUM; p++) begin
            for (int q = p + 1; q < REQ_NUM; q++) begin
               assert (!(req_rdy_o[p] && req_rdy_o[q] &&
                         req_idx_o[p*IDX_W +: IDX_W] == req_idx_o[q*IDX_W +: IDX_W]));
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_rvh_l1d_entry_alloc_sched.sv
// Directed bench for rvh_l1d_entry_alloc_sched (8 entries, 2 ports) plus a short
// randomised run against a free-list reference model.

module tb_rvh_l1d_entry_alloc_sched;
   logic       clk;
   logic       rst;
   logic [1:0] req_vld_i;
   logic [1:0] req_rdy_o;
   logic [5:0] req_idx_o;
   logic [7:0] rel_vld_i;
   logic       flush_i;
   logic [7:0] busy_vec_o;
   logic [3:0] busy_cnt_o;
   logic [3:0] free_cnt_o;
   logic       full_o;
   logic       empty_o;

   int err_cnt = 0;
   int chk_cnt = 0;

   rvh_l1d_entry_alloc_sched #(.ENTRY_NUM(8), .REQ_NUM(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_vld_i  (req_vld_i),
      .req_rdy_o  (req_rdy_o),
      .req_idx_o  (req_idx_o),
      .rel_vld_i  (rel_vld_i),
      .flush_i    (flush_i),
      .busy_vec_o (busy_vec_o),
      .busy_cnt_o (busy_cnt_o),
      .free_cnt_o (free_cnt_o),
      .full_o     (full_o),
      .empty_o    (empty_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] idx(input int p);
      return req_idx_o[p*3 +: 3];
   endfunction

   task automatic chk_reg(input string tag, input logic [7:0] vec, input int cnt);
      chk({tag, "_busy"}, 32'(busy_vec_o), 32'(vec));
      chk({tag, "_cnt"}, 32'(busy_cnt_o), 32'(cnt));
      chk({tag, "_free"}, 32'(free_cnt_o), 32'(8 - cnt));
      chk({tag, "_full"}, 32'(full_o), 32'(cnt == 8));
      chk({tag, "_empty"}, 32'(empty_o), 32'(cnt == 0));
   endtask

   logic [7:0] m_busy;
   int         m_rr;

   initial begin
      rst = 1'b1; req_vld_i = '0; rel_vld_i = '0; flush_i = 1'b0;
      #2;
      chk_reg("rst", 8'h00, 0);
      chk("rst_rdy", 32'(req_rdy_o), 32'h0);
      chk("rst_idx", 32'(req_idx_o), 32'h0);
      #10 rst = 1'b0;
      cyc();

      // T1: fill the pool two at a time
      for (int i = 0; i < 4; i++) begin
         req_vld_i = 2'b11;
         #1;
         chk("t1_rdy", 32'(req_rdy_o), 32'h3);
         chk("t1_idx0", 32'(idx(0)), 32'(2*i));
         chk("t1_idx1", 32'(idx(1)), 32'(2*i + 1));
         cyc();
      end
      chk_reg("t1_end", 8'hFF, 8);
      chk("t1_full_rdy", 32'(req_rdy_o), 32'h0);

      // T2: release 0 and 2 while full, regrant next cycle
      rel_vld_i = 8'h05;
      #1;
      chk("t2_rdy_rel", 32'(req_rdy_o), 32'h0);
      cyc();
      rel_vld_i = '0;
      chk_reg("t2_rel", 8'hFA, 6);
      #1;
      chk("t2_rdy", 32'(req_rdy_o), 32'h3);
      chk("t2_idx0", 32'(idx(0)), 32'h0);
      chk("t2_idx1", 32'(idx(1)), 32'h2);
      cyc();
      chk_reg("t2_end", 8'hFF, 8);

      // T3: one free entry, contention alternates ports
      req_vld_i = 2'b00; rel_vld_i = 8'h01;
      cyc();
      chk_reg("t3_pre", 8'hFE, 7);
      req_vld_i = 2'b11; rel_vld_i = 8'h02;
      #1;
      chk("t3a_rdy", 32'(req_rdy_o), 32'h1);
      chk("t3a_idx0", 32'(idx(0)), 32'h0);
      cyc();
      chk("t3a_busy", 32'(busy_vec_o), 32'hFD);
      rel_vld_i = 8'h04;
      #1;
      chk("t3b_rdy", 32'(req_rdy_o), 32'h2);
      chk("t3b_idx1", 32'(idx(1)), 32'h1);
      cyc();
      chk("t3b_busy", 32'(busy_vec_o), 32'hFB);
      rel_vld_i = 8'h00;
      #1;
      chk("t3c_rdy", 32'(req_rdy_o), 32'h1);
      chk("t3c_idx0", 32'(idx(0)), 32'h2);
      cyc();
      chk_reg("t3_end", 8'hFF, 8);

      // T4: flush a full pool with requests pending (rr_ptr is now 1)
      flush_i = 1'b1; rel_vld_i = 8'h10;
      #1;
      chk("t4_rdy", 32'(req_rdy_o), 32'h0);
      cyc();
      flush_i = 1'b0; rel_vld_i = '0;
      chk_reg("t4_end", 8'h00, 0);

      // T5: port0 alone takes entry 0, then release of idle entry 3
      req_vld_i = 2'b01;
      #1;
      chk("t5_rdy", 32'(req_rdy_o), 32'h1);
      chk("t5_idx0", 32'(idx(0)), 32'h0);
      cyc();
      req_vld_i = 2'b00; rel_vld_i = 8'h08;
      cyc();
      rel_vld_i = '0;
      chk_reg("t5_end", 8'h01, 1);

      // T6: rr_ptr still 1, so port1 is served first; then async reset mid-cycle
      req_vld_i = 2'b11;
      #1;
      chk("t6_rdy", 32'(req_rdy_o), 32'h3);
      chk("t6_idx1", 32'(idx(1)), 32'h1);
      chk("t6_idx0", 32'(idx(0)), 32'h2);
      cyc();
      chk("t6_busy", 32'(busy_vec_o), 32'h07);
      #1 rst = 1'b1;
      #1;
      chk_reg("t6_rst", 8'h00, 0);
      chk("t6_rst_rdy", 32'(req_rdy_o), 32'h0);
      chk("t6_rst_idx", 32'(req_idx_o), 32'h0);
      req_vld_i = 2'b00;
      #1 rst = 1'b0;
      cyc();
      chk_reg("t6_post", 8'h00, 0);

      // Random stress against a free-list model
      m_busy = '0;
      m_rr   = 0;
      for (int n = 0; n < 80; n++) begin
         int         fl[8];
         int         nfree;
         int         kth;
         int         last;
         bit         g;
         bit         d;
         logic [1:0] e_rdy;
         logic [5:0] e_idx;
         logic [7:0] gmask;
         req_vld_i = 2'($urandom_range(0, 3));
         rel_vld_i = 8'($urandom & $urandom & $urandom);
         flush_i   = ($urandom_range(0, 15) == 0);
         nfree = 0;
         for (int i = 0; i < 8; i++) begin
            fl[i] = 0;
            if (!m_busy[i]) begin
               fl[nfree] = i;
               nfree++;
            end
         end
         e_rdy = '0; e_idx = '0; gmask = '0; kth = 0; last = 0; g = 0; d = 0;
         for (int k = 0; k < 2; k++) begin
            int p;
            p = (m_rr + k) % 2;
            if (req_vld_i[p] && !flush_i) begin
               if (kth < nfree) begin
                  e_rdy[p]        = 1'b1;
                  e_idx[p*3 +: 3] = 3'(fl[kth]);
                  gmask[fl[kth]]  = 1'b1;
                  g = 1; last = p;
               end else begin
                  d = 1;
               end
               kth++;
            end
         end
         #1;
         chk("rnd_rdy", 32'(req_rdy_o), 32'(e_rdy));
         chk("rnd_idx", 32'(req_idx_o), 32'(e_idx));
         m_busy = flush_i ? 8'h00 : ((m_busy & ~rel_vld_i) | gmask);
         if (g && d) m_rr = (last + 1) % 2;
         cyc();
         chk("rnd_busy", 32'(busy_vec_o), 32'(m_busy));
         chk("rnd_cnt", 32'(busy_cnt_o), 32'($countones(m_busy)));
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end
endmodule
